imm_gen_stage: RTL and testbench

Registered, parametrised immediate-generation stage for the RISC-V CPU pipelines. It extracts and sign-extends the immediate for all base formats plus CSR-zimm and shift-amount forms, at XLEN of 32 or 64. It also computes the PC-relative target `pc + imm`. It sits between decode and execute and uses valid/ready handshakes with a two-entry skid buffer, so backpressure never creates a combinational path from `out_ready` to `in_ready`.

---
 rtl/imm_gen_stage.sv | 97 +++++++++
 tb/tb_imm_gen_stage.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_stage.sv
// imm_gen_stage: RISC-V immediate extraction plus pc+imm target behind a two-entry skid buffer
module imm_gen_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [2:0]      in_extop,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [XLEN-1:0] out_target,
  output logic [XLEN-1:0] out_pc,
  output logic            out_err
);
  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("imm_gen_stage: XLEN must be 32 or 64");
  end
  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] pc;
    logic            err;
  } entry_t;
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  state_t state_q, state_d;
  entry_t head_q, head_d, skid_q, skid_d, new_e;
  logic [XLEN-1:0] imm;
  logic err, acc, xfer, unused;
  assign unused = ^in_instr[6:0];
  always_comb begin
    imm = '0;
    err = 1'b0;
    case (in_extop)
      3'd0: imm = XLEN'($signed(in_instr[31:20]));
      3'd1: imm = XLEN'($signed({in_instr[31:12], 12'b0}));
      3'd2: imm = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
      3'd3: imm = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0}));
      3'd4: imm = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0}));
      3'd5: imm = XLEN'(in_instr[19:15]);
      3'd6: begin
        imm = XLEN == 64 ? XLEN'(in_instr[25:20]) : XLEN'(in_instr[24:20]);
        err = XLEN == 32 && in_instr[25];
      end
      default: err = 1'b1;
    endcase
  end
  assign new_e = '{imm: imm, target: in_pc + imm, pc: in_pc, err: err};
  assign acc   = in_valid && in_ready && !flush;
  assign xfer  = out_valid && out_ready && !flush;
  // head always feeds the outputs; skid only fills when head is stalled
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: if (acc) begin
        state_d = ONE;
        head_d  = new_e;
      end
      ONE: begin
        if (acc && xfer) head_d = new_e;
        else if (acc) begin
          state_d = FULL;
          skid_d  = new_e;
        end else if (xfer) state_d = EMPTY;
      end
      FULL: if (xfer) begin
        state_d = ONE;
        head_d  = skid_q;
      end
      default: state_d = EMPTY;
    endcase
    if (flush) state_d = EMPTY;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
    end
  end
  assign out_valid  = state_q != EMPTY;
  assign in_ready   = state_q != FULL;
  assign out_imm    = head_q.imm;
  assign out_target = head_q.target;
  assign out_pc     = head_q.pc;
  assign out_err    = head_q.err;
endmodule

// File: tb/tb_imm_gen_stage.sv
// tb_imm_gen_stage: scoreboard bench for imm_gen_stage at XLEN=32 and XLEN=64
module tb_imm_gen_stage;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic        flush = 0, i_valid = 0, i_ready, o_valid, o_ready = 1, o_err;
  logic [31:0] i_instr = 0, i_pc = 0, o_imm, o_target, o_pc;
  logic [2:0]  i_op = 0;
  logic        w_flush = 0, w_valid_in = 0, w_ready, w_valid, w_oready = 1, w_err;
  logic [31:0] w_instr = 0;
  logic [2:0]  w_op = 0;
  logic [63:0] w_pc = 0, w_imm, w_target, w_opc;
  int errors = 0, checks = 0;
  typedef struct {
    logic [63:0] imm;
    logic [63:0] tgt;
    logic [63:0] pc;
    logic        err;
  } exp_t;
  exp_t q32[$], q64[$];

  imm_gen_stage #(.XLEN(32)) dut32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(i_valid), .in_ready(i_ready),
    .in_instr(i_instr), .in_extop(i_op), .in_pc(i_pc), .out_valid(o_valid),
    .out_ready(o_ready), .out_imm(o_imm), .out_target(o_target), .out_pc(o_pc), .out_err(o_err)
  );
  imm_gen_stage #(.XLEN(64)) dut64 (
    .clk(clk), .rst(rst), .flush(w_flush), .in_valid(w_valid_in), .in_ready(w_ready),
    .in_instr(w_instr), .in_extop(w_op), .in_pc(w_pc), .out_valid(w_valid),
    .out_ready(w_oready), .out_imm(w_imm), .out_target(w_target), .out_pc(w_opc), .out_err(w_err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : mon32
    exp_t e;
    if (o_valid && o_ready && !flush && !rst) begin
      if (q32.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL x32 unexpected output: got imm %h expected none", o_imm);
      end else begin
        e = q32.pop_front();
        chk("x32 imm", o_imm, e.imm);
        chk("x32 target", o_target, e.tgt);
        chk("x32 pc", o_pc, e.pc);
        chk("x32 err", o_err, e.err);
      end
    end
  end

  always @(negedge clk) begin : mon64
    exp_t e;
    if (w_valid && w_oready && !w_flush && !rst) begin
      if (q64.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL x64 unexpected output: got imm %h expected none", w_imm);
      end else begin
        e = q64.pop_front();
        chk("x64 imm", w_imm, e.imm);
        chk("x64 target", w_target, e.tgt);
        chk("x64 pc", w_opc, e.pc);
        chk("x64 err", w_err, e.err);
      end
    end
  end

  task automatic send32(input logic [31:0] instr, input logic [2:0] op, input logic [31:0] pc,
                        input logic [31:0] imm, input logic [31:0] tgt, input logic err);
    bit acc = 0;
    i_instr = instr;
    i_op = op;
    i_pc = pc;
    i_valid = 1;
    for (int n = 0; n < 40 && !acc; n++) begin
      @(negedge clk);
      acc = i_ready && !flush;
      @(posedge clk);
      #1;
    end
    i_valid = 0;
    if (acc) q32.push_back('{imm: {32'b0, imm}, tgt: {32'b0, tgt}, pc: {32'b0, pc}, err: err});
    else begin
      checks++;
      errors++;
      $display("FAIL x32 send timeout: got no accept expected accept pc=%h", pc);
    end
  endtask

  task automatic send64(input logic [31:0] instr, input logic [2:0] op, input logic [63:0] pc,
                        input logic [63:0] imm, input logic [63:0] tgt, input logic err);
    bit acc = 0;
    w_instr = instr;
    w_op = op;
    w_pc = pc;
    w_valid_in = 1;
    for (int n = 0; n < 40 && !acc; n++) begin
      @(negedge clk);
      acc = w_ready && !w_flush;
      @(posedge clk);
      #1;
    end
    w_valid_in = 0;
    if (acc) q64.push_back('{imm: imm, tgt: tgt, pc: pc, err: err});
    else begin
      checks++;
      errors++;
      $display("FAIL x64 send timeout: got no accept expected accept pc=%h", pc);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    chk("reset out_valid", o_valid, 0);
    chk("reset in_ready", i_ready, 1);
    chk("reset imm", o_imm, 0);
    chk("reset target", o_target, 0);
    chk("reset pc", o_pc, 0);
    chk("reset err", o_err, 0);
    chk("reset x64 valid", w_valid, 0);
    @(negedge clk) rst = 0;
    @(posedge clk);
    #1;
    send32(32'hFFF00093, 0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    chk("I latency out_valid", o_valid, 1);
    send32(32'hFE000EE3, 3, 32'h100, 32'hFFFFFFFC, 32'h000000FC, 0);
    send32(32'hFE112E23, 2, 32'h10, 32'hFFFFFFFC, 32'h0000000C, 0);
    send32(32'h000F8073, 5, 32'h4, 32'h1F, 32'h23, 0);
    send32(32'h03F01013, 6, 32'h20, 32'h1F, 32'h3F, 1);
    send32(32'h12345678, 7, 32'h200, 32'h0, 32'h200, 1);
    send32(32'h0080006F, 4, 32'h40, 32'h8, 32'h48, 0);
    send32(32'h123450B7, 1, 32'h1000, 32'h12345000, 32'h12346000, 0);
    send64(32'h800000B7, 1, 64'h0, 64'hFFFFFFFF80000000, 64'hFFFFFFFF80000000, 0);
    send64(32'h03F01013, 6, 64'h1000, 64'h3F, 64'h103F, 0);
    send64(32'hFFF00093, 0, 64'h10, 64'hFFFFFFFFFFFFFFFF, 64'hF, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("drain x32", q32.size(), 0);
    chk("drain x64", q64.size(), 0);
    // backpressure: two entries fill head and skid, third waits
    o_ready = 0;
    send32(32'h00100093, 0, 32'h300, 32'h1, 32'h301, 0);
    send32(32'h00200093, 0, 32'h304, 32'h2, 32'h306, 0);
    chk("full in_ready", i_ready, 0);
    i_instr = 32'h00300093;
    i_op = 0;
    i_pc = 32'h308;
    i_valid = 1;
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("hold in_ready", i_ready, 0);
      chk("hold out_valid", o_valid, 1);
      chk("hold imm", o_imm, 32'h1);
    end
    o_ready = 1;
    send32(32'h00300093, 0, 32'h308, 32'h3, 32'h30B, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("drain backpressure", q32.size(), 0);
    // flush while FULL
    o_ready = 0;
    send32(32'h00400093, 0, 32'h400, 32'h4, 32'h404, 0);
    send32(32'h00500093, 0, 32'h404, 32'h5, 32'h409, 0);
    chk("pre-flush in_ready", i_ready, 0);
    i_instr = 32'h00600093;
    i_pc = 32'h408;
    i_valid = 1;
    flush = 1;
    @(posedge clk);
    #1;
    flush = 0;
    i_valid = 0;
    q32.delete();
    chk("flush full out_valid", o_valid, 0);
    chk("flush full in_ready", i_ready, 1);
    // flush while ONE with a same-cycle offer that must be void
    send32(32'h00400093, 0, 32'h400, 32'h4, 32'h404, 0);
    i_instr = 32'h00600093;
    i_pc = 32'h408;
    i_valid = 1;
    flush = 1;
    @(posedge clk);
    #1;
    flush = 0;
    i_valid = 0;
    q32.delete();
    chk("flush one out_valid", o_valid, 0);
    o_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("flush no accept", o_valid, 0);
    // async reset mid-stream
    o_ready = 0;
    send32(32'h00700093, 0, 32'h500, 32'h7, 32'h507, 0);
    #1;
    rst = 1;
    #1;
    chk("async rst out_valid", o_valid, 0);
    chk("async rst in_ready", i_ready, 1);
    chk("async rst imm", o_imm, 0);
    chk("async rst target", o_target, 0);
    chk("async rst pc", o_pc, 0);
    chk("async rst err", o_err, 0);
    q32.delete();
    @(negedge clk) rst = 0;
    @(posedge clk);
    #1;
    o_ready = 1;
    send32(32'h00800093, 0, 32'h600, 32'h8, 32'h608, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("final x32", q32.size(), 0);
    chk("final x64", q64.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
